// File: rtl/wn_table_ctrl.sv
// Twiddle-factor RAM controller: sequences a one-shot table load from the loader
// stream, then serves (stage, index) twiddle fetches with one-cycle latency.
module wn_table_ctrl #(
  parameter int N_LOG2 = 10,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              flush,
  input  logic              fft_req_valid,
  input  logic [3:0]        fft_req_stage,
  input  logic [N_LOG2-2:0] fft_req_idx,
  output logic              fft_req_ready,
  output logic              tw_valid,
  output logic [DATA_W-1:0] tw_data,
  output logic              tw_err,
  output logic              table_ready,
  output logic [N_LOG2-1:0] table_len,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int DEPTH = 2 ** (N_LOG2 - 1);
  localparam int PTR_W = N_LOG2 - 1;

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [N_LOG2-1:0]   r_len;
  logic                r_tw_valid;
  logic                r_tw_err;
  logic [DATA_W-1:0]   r_tw_data;

  logic                w_load_ready;
  logic                w_req_ready;
  logic                w_load_acc;
  logic                w_req_acc;
  logic                w_bad_stage;
  logic                w_last_word;
  logic [PTR_W-1:0]    w_ptr;
  logic [3:0]          w_shamt;
  logic [PTR_W-1:0]    w_fetch_addr;

  // The word count doubles as the write pointer; it is 0 in EMPTY, so the first
  // word naturally lands at address 0.
  assign w_ptr        = r_len[PTR_W-1:0];
  assign w_last_word  = load_last || (w_ptr == PTR_W'(DEPTH - 1));
  assign w_bad_stage  = {1'b0, fft_req_stage} >= 5'(N_LOG2);
  assign w_shamt      = 4'(N_LOG2 - 1) - fft_req_stage;
  // Truncation to PTR_W bits is the modulo-table-depth mask.
  assign w_fetch_addr = fft_req_idx << w_shamt;
  assign w_load_acc   = w_load_ready && load_valid;
  assign w_req_acc    = w_req_ready && fft_req_valid;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_req_ready  = 1'b0;
    table_ready  = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (r_state)
      S_EMPTY: begin
        w_load_ready = !rst;
        if (w_load_acc) w_next_state = w_last_word ? S_READY : S_LOAD;
      end
      S_LOAD: begin
        w_load_ready = !rst && !flush;
        if (flush)           w_next_state = S_EMPTY;
        else if (w_load_acc) w_next_state = w_last_word ? S_READY : S_LOAD;
      end
      S_READY: begin
        table_ready = 1'b1;
        w_req_ready = !rst;
        if (flush) w_next_state = S_EMPTY;
      end
      default: w_next_state = S_EMPTY;
    endcase

    if (w_load_acc) begin
      ram_we    = 1'b1;
      ram_addr  = ADDR_W'(w_ptr);
      ram_wdata = load_data;
    end else if (w_req_acc && !w_bad_stage) begin
      ram_addr  = ADDR_W'(w_fetch_addr);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_len      <= '0;
      r_tw_valid <= 1'b0;
      r_tw_err   <= 1'b0;
      r_tw_data  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_tw_valid <= w_req_acc;
      if (w_load_acc)
        r_len <= r_len + N_LOG2'(1);
      else if (flush && r_state != S_EMPTY)
        r_len <= '0;
      if (w_req_acc) begin
        r_tw_err  <= w_bad_stage;
        r_tw_data <= w_bad_stage ? '0 : ram_rdata;
      end
    end
  end

  assign load_ready    = w_load_ready;
  assign fft_req_ready = w_req_ready;
  assign tw_valid      = r_tw_valid;
  assign tw_err        = r_tw_err;
  assign tw_data       = r_tw_data;
  assign table_len     = r_len;

endmodule

// File: tb/tb_wn_table_ctrl.sv
// Self-checking bench for wn_table_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a table/counter reference model.
module tb_wn_table_ctrl;

  localparam int N_LOG2 = 10;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** (N_LOG2 - 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              flush;
  logic              fft_req_valid;
  logic [3:0]        fft_req_stage;
  logic [N_LOG2-2:0] fft_req_idx;
  logic              fft_req_ready;
  logic              tw_valid;
  logic [DATA_W-1:0] tw_data;
  logic              tw_err;
  logic              table_ready;
  logic [N_LOG2-1:0] table_len;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  wn_table_ctrl #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .flush(flush),
    .fft_req_valid(fft_req_valid), .fft_req_stage(fft_req_stage),
    .fft_req_idx(fft_req_idx), .fft_req_ready(fft_req_ready),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_err(tw_err),
    .table_ready(table_ready), .table_len(table_len),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Bench-side RAM with combinational read.
  logic [DATA_W-1:0] mem [1024];
  always @(posedge clk) if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
  assign ram_rdata = mem[ram_addr[9:0]];

  int n_total = 0;
  int n_bad   = 0;
  int wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected RAM image, words loaded so far, and whether
  // the table is complete. Starts in the reset condition.
  logic [DATA_W-1:0] m_tab [DEPTH];
  int                m_count    = 0;
  bit                m_ready    = 0;
  bit                m_tw_valid = 0;
  bit                m_tw_err   = 0;
  logic [DATA_W-1:0] m_tw_data  = '0;

  // Sampled at the falling edge: inputs are stable and reflect what the next
  // rising edge will see; registered outputs reflect the previous rising edge.
  always @(negedge clk) begin
    bit e_load_ready, e_req_ready, acc_load, acc_req, bad;
    bit e_we;
    int e_addr;
    logic [DATA_W-1:0] e_wd;

    check("tw_valid", tw_valid, m_tw_valid);
    if (m_tw_valid) begin
      check("tw_err", tw_err, m_tw_err);
      check("tw_data", tw_data, m_tw_data);
    end else begin
      check("tw_data_hold", tw_data, m_tw_data);
    end
    check("table_ready", table_ready, m_ready);
    check("table_len", table_len, m_count);

    e_load_ready = !rst && !m_ready && !(flush && m_count != 0);
    e_req_ready  = !rst && m_ready;
    check("load_ready", load_ready, e_load_ready);
    check("fft_req_ready", fft_req_ready, e_req_ready);

    acc_load = load_valid && e_load_ready;
    acc_req  = fft_req_valid && e_req_ready;
    bad      = int'(fft_req_stage) >= N_LOG2;
    e_we = 0; e_addr = 0; e_wd = '0;
    if (acc_load) begin
      e_we = 1; e_addr = m_count; e_wd = load_data;
    end else if (acc_req && !bad) begin
      e_addr = (int'(fft_req_idx) * (1 << (N_LOG2 - 1 - int'(fft_req_stage)))) % DEPTH;
    end
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_wdata", ram_wdata, e_wd);
    if (ram_we) wr_count++;

    if (rst) begin
      m_count = 0; m_ready = 0; m_tw_valid = 0; m_tw_err = 0; m_tw_data = '0;
    end else begin
      m_tw_valid = acc_req;
      if (acc_req) begin
        m_tw_err  = bad;
        m_tw_data = bad ? '0 : m_tab[e_addr];
      end
      if (acc_load) begin
        m_tab[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) m_ready = 1;
      end else if (flush && (m_count != 0 || m_ready)) begin
        m_count = 0; m_ready = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_valid = 0; load_data = '0; load_last = 0; flush = 0;
    fft_req_valid = 0; fft_req_stage = '0; fft_req_idx = '0;
  endtask

  task automatic req(input int s, input int j);
    fft_req_valid = 1; fft_req_stage = 4'(s); fft_req_idx = (N_LOG2-1)'(j);
  endtask

  initial begin
    rst = 1;
    idle();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (i < DEPTH) m_tab[i] = mem[i];
    end

    // Reset state
    step();
    check("rst_tw_valid", tw_valid, 0);
    check("rst_table_ready", table_ready, 0);
    check("rst_table_len", table_len, 0);
    check("rst_tw_data", tw_data, 0);
    check("rst_load_ready", load_ready, 0);
    rst = 0;
    #1;
    check("empty_load_ready", load_ready, 1);
    check("empty_req_ready", fft_req_ready, 0);

    // Full 512-word load terminated by load_last
    wr_count = 0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      load_valid = 1; load_data = k; load_last = (k == DEPTH - 1);
      #1;
      check("load_addr", ram_addr, k);
    end
    step();
    idle();
    #1;
    check("full_table_ready", table_ready, 1);
    check("full_table_len", table_len, 512);
    check("full_write_count", wr_count, 512);

    // Back-to-back fetches, then an illegal stage
    step(); req(9, 5);  #1; check("fetch_addr_a", ram_addr, 5);
    step(); req(0, 0);  #1; check("fetch_addr_b", ram_addr, 0);
    check("resp_a_valid", tw_valid, 1); check("resp_a_data", tw_data, 5);
    step(); req(1, 1);  #1; check("fetch_addr_c", ram_addr, 256);
    check("resp_b_valid", tw_valid, 1); check("resp_b_data", tw_data, 0);
    step(); req(12, 3); #1; check("bad_no_we", ram_we, 0); check("bad_addr", ram_addr, 0);
    check("resp_c_valid", tw_valid, 1); check("resp_c_data", tw_data, 256);
    step(); idle(); #1;
    check("bad_valid", tw_valid, 1); check("bad_err", tw_err, 1); check("bad_data", tw_data, 0);
    step(); #1;
    check("gap_valid", tw_valid, 0); check("gap_hold", tw_data, 0);

    // Random fetches in READY; load traffic must be ignored
    for (int c = 0; c < 400; c++) begin
      step();
      idle();
      if ($urandom_range(0, 3) != 0) req($urandom_range(0, 15), $urandom_range(0, DEPTH - 1));
      load_valid = $urandom_range(0, 1); load_data = $urandom; load_last = $urandom_range(0, 1);
    end

    // Flush together with a request in READY
    step(); idle(); req(9, 7); flush = 1; #1;
    check("flush_still_ready", table_ready, 1);
    step(); idle(); #1;
    check("flush_resp_valid", tw_valid, 1); check("flush_resp_data", tw_data, 7);
    check("flush_table_ready", table_ready, 0); check("flush_load_ready", load_ready, 1);

    // 513 words without load_last: auto-terminate after word 511
    for (int k = 0; k <= DEPTH; k++) begin
      step();
      load_valid = 1; load_data = 32'h1000 + k; load_last = 0;
      #1;
      check("auto_load_ready", load_ready, k < DEPTH);
    end
    step(); idle(); #1;
    check("auto_table_len", table_len, 512);
    check("auto_table_ready", table_ready, 1);
    step(); req(9, 300); step(); idle(); #1;
    check("auto_fetch_data", tw_data, 32'h1000 + 300);

    // Randomized mix of loads, flushes, resets and requests
    for (int c = 0; c < 3000; c++) begin
      step();
      idle();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 9) < 6);
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) != 0) req($urandom_range(0, 15), $urandom_range(0, DEPTH - 1));
    end

    // Reset in the middle of a load, then a short reload
    step(); idle(); rst = 1;
    step(); rst = 0;
    for (int k = 0; k < 100; k++) begin
      step(); load_valid = 1; load_data = 32'hA000 + k;
    end
    step(); idle(); rst = 1;
    step(); rst = 0; #1;
    check("midrst_table_len", table_len, 0);
    for (int k = 0; k < 4; k++) begin
      step(); load_valid = 1; load_data = 32'hB000 + k; load_last = (k == 3);
      #1;
      check("reload_addr", ram_addr, k);
    end
    step(); idle(); #1;
    check("reload_table_len", table_len, 4);
    check("reload_table_ready", table_ready, 1);

    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wn_table_ctrl.md
Name: wn_table_ctrl

Overview:
- Controller for the 1024x32 twiddle-factor (Wn) RAM used by the FFT core.
- Sequences a one-shot table load from the host/ROM-loader stream into the RAM.
- Once the table is complete, serves twiddle fetches from the butterfly engine, converting (stage, butterfly index) into a RAM address.
- Sits between the loader, the butterfly engine and the RAM; it is the sole driver of the RAM's we/addr/data_i.

Parameters:
N_LOG2, 10, log2 of FFT length; table depth is 2^(N_LOG2-1) words (512 for the default).
ADDR_W, 16, RAM address width.
DATA_W, 32, twiddle word width ({im[15:0], re[15:0]}).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
load_valid  in  1  loader word valid
load_data  in  DATA_W  twiddle word
load_last  in  1  marks final word of the table
load_ready  out  1  controller accepts load word this cycle
flush  in  1  invalidate the table and return to EMPTY
fft_req_valid  in  1  butterfly engine twiddle request
fft_req_stage  in  4  FFT stage s, 0..N_LOG2-1
fft_req_idx  in  N_LOG2-1  butterfly position j within group
fft_req_ready  out  1  request accepted this cycle
tw_valid  out  1  twiddle response valid
tw_data  out  DATA_W  twiddle word
tw_err  out  1  response is for an illegal stage (data forced 0)
table_ready  out  1  table complete, fetches allowed
table_len  out  N_LOG2  number of words loaded
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (combinational read in the RAM)

Behaviour:
- Reset (rst=1 at clk edge): state EMPTY, write pointer 0, table_len 0, tw_valid 0, tw_data 0, tw_err 0, table_ready 0. RAM contents are not cleared; they are treated as invalid.
- Combinational defaults: ram_we=0, ram_addr=0, ram_wdata=0 when no operation is taking place.
- States:
  - EMPTY: load_ready=1, fft_req_ready=0. An accepted word (load_valid & load_ready) writes addr 0 and goes to LOAD, or directly to READY if load_last is set.
  - LOAD: load_ready=1. Each accepted word drives ram_we=1, ram_addr=ptr, ram_wdata=load_data, then ptr+1. Go to READY when load_last is accepted, or when the word at ptr = 2^(N_LOG2-1)-1 is accepted (auto-terminate; ptr never wraps). table_len = words accepted.
  - READY: table_ready=1, load_ready=0, fft_req_ready=1. load_valid is ignored (not consumed).
- Fetch address: ram_addr = (fft_req_idx << (N_LOG2-1-stage)) & (2^(N_LOG2-1)-1), driven combinationally in the accept cycle with ram_we=0.
- Fetch response latency is 1 cycle: on the following cycle tw_valid=1 and tw_data = ram_rdata as registered in the accept cycle. Throughput is one request per cycle, responses in order.
- If fft_req_stage >= N_LOG2: the request is still accepted, no RAM access is made, and the response has tw_err=1, tw_data=0.
- Any cycle without an accepted request gives tw_valid=0 next cycle; tw_data holds its last value.
- Flush:
  - In LOAD: return to EMPTY with ptr=0 and table_len=0. A load word offered in the same cycle is not accepted.
  - In READY: a request presented in the same cycle is accepted and its response is issued next cycle. State becomes EMPTY next cycle.
  - In EMPTY: no effect.
- rst has priority over flush and all other inputs.
- Reset mid-load discards the partial table.

Test Plan:
- Load 512 words, data=0x0000_0000+k, load_last on k=511 -> 512 ram_we pulses at addr 0..511, table_ready=1 on the cycle after the last word, table_len=512.
- Load 513 words with no load_last -> auto-terminate after word 511, load_ready=0 in READY, word 512 not consumed, table_len=512.
- READY; back-to-back requests (s=9,j=5), (s=0,j=0), (s=1,j=1) -> ram_addr 5, 0, 256; tw_valid high on 3 consecutive cycles with the matching data, 1-cycle latency each.
- Request with s=12 -> tw_valid=1, tw_err=1, tw_data=0, no RAM access in the accept cycle.
- flush asserted together with a request in READY -> response delivered next cycle, table_ready=0, state EMPTY, load_ready=1.
- Assert rst after 100 load words, then reload 4 words with load_last -> table_len=4, writes at addr 0..3.
